ram_port_arbiter: RTL
=====================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 2, word width of the shared dual-port RAM.
REQ-002 SHALL have parameter ADDR_WIDTH, default 2, address width of the shared dual-port RAM.
REQ-003 SHALL have one clock and synchronous active-high reset: CLK input 1, rising-edge clock; RST input 1, synchronous active-high reset.
REQ-004 SHALL have, per requester n in {0,1}: WR_REQ_n input 1, write request; WR_ADDR_n input ADDR_WIDTH, write address; WR_DATA_n input DATA_WIDTH, write data; WR_GNT_n output 1, write accepted this cycle.
REQ-005 SHALL have, per requester n in {0,1}: RD_REQ_n input 1, read request; RD_ADDR_n input ADDR_WIDTH, read address; RD_GNT_n output 1, read accepted this cycle.
REQ-006 SHALL have, per requester n in {0,1}: RD_VALID_n output 1, read data valid; RD_DATA_n output DATA_WIDTH, read data.
REQ-007 SHALL have RAM-side write port: EN_WR output 1; ADDR_WR output ADDR_WIDTH; D_IN output DATA_WIDTH.
REQ-008 SHALL have RAM-side read port: EN_RD output 1; ADDR_RD output ADDR_WIDTH; D_OUT input DATA_WIDTH, registered RAM read data.

Function
REQ-009 SHALL arbitrate write port and read port independently; each grants at most one requester per cycle.
REQ-010 SHALL make grants combinational in the request cycle: a lone requester is granted; on contention, the requester holding priority is granted.
REQ-011 SHALL keep one registered priority bit per port (WR_PRI, RD_PRI); after a grant to requester n, that port's priority moves to requester 1-n on the next edge; with no grant, priority holds.
REQ-012 SHALL drive EN_WR = WR_GNT_0 | WR_GNT_1, with ADDR_WR/D_IN muxed from the granted requester; ADDR_WR/D_IN = 0 when no write grant.
REQ-013 SHALL drive EN_RD = RD_GNT_0 | RD_GNT_1, with ADDR_RD muxed from the granted requester; ADDR_RD = 0 when no read grant.
REQ-014 SHALL register a read tag (valid bit plus granted index) at the grant edge; RD_VALID_n is asserted exactly one cycle after RD_GNT_n, i.e. the cycle D_OUT reflects that read.
REQ-015 SHALL drive RD_DATA_n = D_OUT while RD_VALID_n = 1, else 0.
REQ-016 SHALL sustain back-to-back reads: a grant every cycle yields RD_VALID every cycle, 1-cycle latency, no bubbles.
REQ-017 SHALL NOT forward data: a same-cycle write and read to one address returns the pre-write RAM contents.
REQ-018 SHALL hold requesters responsible for keeping REQ/ADDR/DATA stable until granted; an ungranted request is not stored.
REQ-019 SHALL allow a requester to hold WR_REQ and RD_REQ in the same cycle; both may be granted.

Reset
REQ-020 SHALL, while RST = 1, force all WR_GNT_n, RD_GNT_n, EN_WR, EN_RD low and ADDR_WR, ADDR_RD, D_IN to 0, regardless of requests.
REQ-021 SHALL, on a clock edge with RST = 1, set WR_PRI = RD_PRI = 0 (requester 0 favoured) and clear the read tag, so RD_VALID_0/1 = 0 and RD_DATA_0/1 = 0 the following cycle.
REQ-022 SHALL discard a read granted in the cycle before RST is asserted: no RD_VALID follows it.

Verification
REQ-023 SHALL pass: reset, then WR_REQ_0 with addr 1, data 2 -> WR_GNT_0=1, EN_WR=1, ADDR_WR=1, D_IN=2 same cycle.
REQ-024 SHALL pass: after reset, WR_REQ_0 and WR_REQ_1 held for 4 cycles -> grants 0,1,0,1; EN_WR high all 4 cycles.
REQ-025 SHALL pass: mem[3]=1 written, then RD_REQ_1 addr 3 -> RD_GNT_1 in cycle t; RD_VALID_1=1, RD_DATA_1=1 in t+1; RD_VALID_0=0, RD_DATA_0=0.
REQ-026 SHALL pass: both requesters read addrs 0 and 2 every cycle for 4 cycles -> RD_VALID alternates 0,1,0,1 from cycle t+1 with matching data, no gaps.
REQ-027 SHALL pass: mem[2]=0, same cycle write addr 2 data 3 and read addr 2 -> read returns 0; next read of addr 2 returns 3.
REQ-028 SHALL pass: read granted at cycle t, RST=1 at t+1 -> RD_VALID=0 at t+1 and t+2, and priority back to requester 0 afterward.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a dual-port RAM.
// slave: arbiter view; master: requesters plus RAM view.
interface ram_port_arbiter_if #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 2
);
  logic                  WR_REQ_0;
  logic [ADDR_WIDTH-1:0] WR_ADDR_0;
  logic [DATA_WIDTH-1:0] WR_DATA_0;
  logic                  WR_GNT_0;
  logic                  WR_REQ_1;
  logic [ADDR_WIDTH-1:0] WR_ADDR_1;
  logic [DATA_WIDTH-1:0] WR_DATA_1;
  logic                  WR_GNT_1;

  logic                  RD_REQ_0;
  logic [ADDR_WIDTH-1:0] RD_ADDR_0;
  logic                  RD_GNT_0;
  logic                  RD_VALID_0;
  logic [DATA_WIDTH-1:0] RD_DATA_0;
  logic                  RD_REQ_1;
  logic [ADDR_WIDTH-1:0] RD_ADDR_1;
  logic                  RD_GNT_1;
  logic                  RD_VALID_1;
  logic [DATA_WIDTH-1:0] RD_DATA_1;

  logic                  EN_WR;
  logic [ADDR_WIDTH-1:0] ADDR_WR;
  logic [DATA_WIDTH-1:0] D_IN;
  logic                  EN_RD;
  logic [ADDR_WIDTH-1:0] ADDR_RD;
  logic [DATA_WIDTH-1:0] D_OUT;

  modport slave (
    input  WR_REQ_0, WR_ADDR_0, WR_DATA_0,
    input  WR_REQ_1, WR_ADDR_1, WR_DATA_1,
    input  RD_REQ_0, RD_ADDR_0,
    input  RD_REQ_1, RD_ADDR_1,
    input  D_OUT,
    output WR_GNT_0, WR_GNT_1,
    output RD_GNT_0, RD_GNT_1,
    output RD_VALID_0, RD_DATA_0,
    output RD_VALID_1, RD_DATA_1,
    output EN_WR, ADDR_WR, D_IN,
    output EN_RD, ADDR_RD
  );

  modport master (
    output WR_REQ_0, WR_ADDR_0, WR_DATA_0,
    output WR_REQ_1, WR_ADDR_1, WR_DATA_1,
    output RD_REQ_0, RD_ADDR_0,
    output RD_REQ_1, RD_ADDR_1,
    output D_OUT,
    input  WR_GNT_0, WR_GNT_1,
    input  RD_GNT_0, RD_GNT_1,
    input  RD_VALID_0, RD_DATA_0,
    input  RD_VALID_1, RD_DATA_1,
    input  EN_WR, ADDR_WR, D_IN,
    input  EN_RD, ADDR_RD
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one dual-port RAM between two requesters.
// Ports: CLK, RST (sync, active-high), bus (slave: reqs, grants, RAM port).
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 2
) (
  input logic             CLK,
  input logic             RST,
  ram_port_arbiter_if.slave bus
);
  logic wr_pri_q, wr_pri_d;
  logic rd_pri_q, rd_pri_d;
  logic tag_vld_q, tag_vld_d;
  logic tag_idx_q, tag_idx_d;

  logic wr_gnt_0, wr_gnt_1;
  logic rd_gnt_0, rd_gnt_1;
  logic rd_vld_0, rd_vld_1;

  logic [ADDR_WIDTH-1:0] addr_wr;
  logic [DATA_WIDTH-1:0] d_in;
  logic [ADDR_WIDTH-1:0] addr_rd;

  always_comb begin
    wr_gnt_0 = 1'b0;
    wr_gnt_1 = 1'b0;
    rd_gnt_0 = 1'b0;
    rd_gnt_1 = 1'b0;
    if (!RST) begin
      // pri bit names the requester that wins a tie
      wr_gnt_0 = bus.WR_REQ_0 & (~bus.WR_REQ_1 | ~wr_pri_q);
      wr_gnt_1 = bus.WR_REQ_1 & (~bus.WR_REQ_0 |  wr_pri_q);
      rd_gnt_0 = bus.RD_REQ_0 & (~bus.RD_REQ_1 | ~rd_pri_q);
      rd_gnt_1 = bus.RD_REQ_1 & (~bus.RD_REQ_0 |  rd_pri_q);
    end
  end

  always_comb begin
    addr_wr = '0;
    d_in    = '0;
    unique case (1'b1)
      wr_gnt_0: begin
        addr_wr = bus.WR_ADDR_0;
        d_in    = bus.WR_DATA_0;
      end
      wr_gnt_1: begin
        addr_wr = bus.WR_ADDR_1;
        d_in    = bus.WR_DATA_1;
      end
      default: ;
    endcase
  end

  always_comb begin
    addr_rd = '0;
    unique case (1'b1)
      rd_gnt_0: addr_rd = bus.RD_ADDR_0;
      rd_gnt_1: addr_rd = bus.RD_ADDR_1;
      default: ;
    endcase
  end

  always_comb begin
    wr_pri_d = wr_pri_q;
    if (wr_gnt_0)      wr_pri_d = 1'b1;
    else if (wr_gnt_1) wr_pri_d = 1'b0;
    rd_pri_d = rd_pri_q;
    if (rd_gnt_0)      rd_pri_d = 1'b1;
    else if (rd_gnt_1) rd_pri_d = 1'b0;
    tag_vld_d = rd_gnt_0 | rd_gnt_1;
    tag_idx_d = rd_gnt_1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_pri_q  <= 1'b0;
      rd_pri_q  <= 1'b0;
      tag_vld_q <= 1'b0;
      tag_idx_q <= 1'b0;
    end else begin
      wr_pri_q  <= wr_pri_d;
      rd_pri_q  <= rd_pri_d;
      tag_vld_q <= tag_vld_d;
      tag_idx_q <= tag_idx_d;
    end
  end

  // Gating by RST drops a read granted just before reset asserts.
  assign rd_vld_0 = ~RST & tag_vld_q & ~tag_idx_q;
  assign rd_vld_1 = ~RST & tag_vld_q &  tag_idx_q;

  assign bus.WR_GNT_0   = wr_gnt_0;
  assign bus.WR_GNT_1   = wr_gnt_1;
  assign bus.RD_GNT_0   = rd_gnt_0;
  assign bus.RD_GNT_1   = rd_gnt_1;
  assign bus.EN_WR      = wr_gnt_0 | wr_gnt_1;
  assign bus.ADDR_WR    = addr_wr;
  assign bus.D_IN       = d_in;
  assign bus.EN_RD      = rd_gnt_0 | rd_gnt_1;
  assign bus.ADDR_RD    = addr_rd;
  assign bus.RD_VALID_0 = rd_vld_0;
  assign bus.RD_VALID_1 = rd_vld_1;
  assign bus.RD_DATA_0  = rd_vld_0 ? bus.D_OUT : '0;
  assign bus.RD_DATA_1  = rd_vld_1 ? bus.D_OUT : '0;
endmodule
